branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Consumer end of the ALU status-flag path. Holds the N/V/Z status register loaded on CMP, owns the program counter, and resolves branch instructions (B, BEQ, BNE, BLT, BLE, BL, BX, BLX) issued by the controller FSM.
- Uses a request/ready/done handshake with a fixed 2-cycle resolve latency.
- Produces the next PC and a link-register write for the register file.

Parameters:
- PC_W, 9, program counter width in bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flag_load  input  1  capture N_in/V_in/Z_in into status register (asserted by controller on CMP)
- N_in, V_in, Z_in  input  1 each  ALU flags
- pc_inc  input  1  sequential PC increment request
- br_valid  input  1  branch request
- br_op  input  2  00 conditional, 01 BL, 10 BX, 11 BLX
- br_cond  input  3  condition for br_op=00
- br_imm  input  8  signed PC-relative offset
- br_reg  input  16  register operand for BX/BLX
- br_ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse at commit
- taken  output  1  valid with done; branch taken
- cond_err  output  1  valid with done; illegal br_cond
- pc  output  PC_W  current program counter
- link_we  output  1  one-cycle pulse with done for BL/BLX
- link_data  output  16  zero-extended (accepted PC + 1), valid with link_we
- status  output  3  {N,V,Z} status register

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, status=000, state=IDLE.
  - done, taken, cond_err, link_we, link_data = 0; br_ready=1.
- Status register:
  - Loads {N_in,V_in,Z_in} on any edge with flag_load=1, independent of FSM state. Otherwise holds.
- States: IDLE, EVAL, COMMIT.
- IDLE:
  - br_valid=1: latch op/cond/imm/reg, snapshot pc and the pre-edge status (a same-edge flag_load is not visible to this branch), go to EVAL.
  - Else pc_inc=1: pc <= pc+1, wrapping mod 2^PC_W.
  - br_valid and pc_inc together: branch wins; the increment is dropped.
- EVAL:
  - Registers taken, target and link using the snapshotted values. Goes to COMMIT.
  - br_valid and pc_inc are ignored (br_ready=0).
- COMMIT:
  - done=1. If taken: pc <= target, else pc <= snapshot pc + 1.
  - link_we=1 for BL/BLX. Returns to IDLE.
  - Latency: accept edge → done high 2 cycles later. Next accept is possible on the edge after done.
- Conditions (br_op=00):
  - 000 B: always.
  - 001 BEQ: Z.
  - 010 BNE: !Z.
  - 011 BLT: N^V.
  - 100 BLE: (N^V)|Z.
  - 101–111: not taken, cond_err=1.
- Target computation:
  - op 00/01: snapshot pc + 1 + sign-extended br_imm, truncated mod 2^PC_W.
  - op 10/11: br_reg[PC_W-1:0]; upper bits ignored.
  - BL/BX/BLX are always taken; br_cond is ignored and cond_err=0.
- Outputs taken and cond_err hold their value until the next commit. done and link_we are pulses.
- Reset mid-operation (EVAL/COMMIT): returns immediately to IDLE. No done or link_we is emitted, and pc=RESET_PC.

Test Plan:
- Reset, then 3 pc_inc cycles → pc=3, br_ready=1, status=000, done never asserted.
- flag_load with Z=1; BEQ with imm=0xFE at pc=0x010 → done exactly 2 cycles after accept, taken=1, pc=0x00F. Repeat as BNE → taken=0, pc=0x011.
- Status N=1,V=0; BLT imm=+5 at pc=0x1FD → pc=(0x1FD+6) mod 512=0x003 (wrap). Same with N=1,V=1 → not taken, pc=0x1FE.
- BL imm=+3 at pc=0x020 → link_we pulse with link_data=0x0021, pc=0x024. BLX br_reg=0xFE40 → pc=0x040, link_data=pc_snapshot+1.
- br_cond=110 → done with cond_err=1, taken=0, pc=+1. br_valid+pc_inc in the same IDLE cycle → only the branch is effective. flag_load in the accept cycle → old flags used.
- Assert reset_n=0 while in EVAL → pc=RESET_PC, no done/link_we pulse. After release, a new branch completes normally.

Source files
------------

// File: rtl/branch_unit_if.sv
// Branch request/response bundle between the controller and the branch unit.
// Latency: none (wires only).
// Backpressure: controller may only present br_valid while br_ready is high.
interface branch_unit_if;
  logic        br_valid;
  logic        br_ready;
  logic [1:0]  br_op;
  logic [2:0]  br_cond;
  logic [7:0]  br_imm;
  logic [15:0] br_reg;
  logic        done;
  logic        taken;
  logic        cond_err;
  logic        link_we;
  logic [15:0] link_data;

  modport master (
    output br_valid, br_op, br_cond, br_imm, br_reg,
    input  br_ready, done, taken, cond_err, link_we, link_data
  );

  modport slave (
    input  br_valid, br_op, br_cond, br_imm, br_reg,
    output br_ready, done, taken, cond_err, link_we, link_data
  );
endinterface

// File: rtl/branch_unit.sv
// Branch unit: N/V/Z status register, program counter, branch resolution.
// Latency: accept edge -> done pulse two cycles later, new accept on the edge after done.
// Backpressure: br_ready is high only in IDLE; requests and pc_inc are ignored otherwise.
module branch_unit #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flag_load,
  input  logic            N_in,
  input  logic            V_in,
  input  logic            Z_in,
  input  logic            pc_inc,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      status,
  branch_unit_if.slave    br
);

  typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      status_q, status_d;
  logic [1:0]      op_q, op_d;
  logic [2:0]      cond_q, cond_d;
  logic [7:0]      imm_q, imm_d;
  logic [PC_W-1:0] reg_q, reg_d;
  logic [PC_W-1:0] pcs_q, pcs_d;      // pc snapshot at accept
  logic [2:0]      snap_q, snap_d;    // status snapshot at accept
  logic            taken_q, taken_d;
  logic            cond_err_q, cond_err_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [15:0]     link_q, link_d;

  logic [PC_W-1:0] imm_ext;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] rel_target;
  logic            cond_hit;
  logic            cond_bad;
  logic            n_s, v_s, z_s;

  // Condition decode and target arithmetic on the snapshotted operands.
  always_comb begin
    {n_s, v_s, z_s} = snap_q;
    imm_ext    = PC_W'($signed(imm_q));
    seq_pc     = pcs_q + PC_ONE;
    rel_target = seq_pc + imm_ext;
    cond_hit   = 1'b0;
    cond_bad   = 1'b0;
    case (cond_q)
      3'b000:  cond_hit = 1'b1;
      3'b001:  cond_hit = z_s;
      3'b010:  cond_hit = ~z_s;
      3'b011:  cond_hit = n_s ^ v_s;
      3'b100:  cond_hit = (n_s ^ v_s) | z_s;
      default: cond_bad = 1'b1;
    endcase
  end

  // Next-state logic: status load, accept/increment, evaluate, commit.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    cond_d     = cond_q;
    imm_d      = imm_q;
    reg_d      = reg_q;
    pcs_d      = pcs_q;
    snap_d     = snap_q;
    taken_d    = taken_q;
    cond_err_d = cond_err_q;
    target_d   = target_q;
    link_d     = link_q;
    // Status loads on any edge; a branch accepted on the same edge keeps the old value.
    status_d   = flag_load ? {N_in, V_in, Z_in} : status_q;

    case (state_q)
      IDLE: begin
        if (br.br_valid) begin
          op_d    = br.br_op;
          cond_d  = br.br_cond;
          imm_d   = br.br_imm;
          reg_d   = br.br_reg[PC_W-1:0];
          pcs_d   = pc_q;
          snap_d  = status_q;
          state_d = EVAL;
        end else if (pc_inc) begin
          pc_d = pc_q + PC_ONE;
        end
      end
      EVAL: begin
        link_d = 16'(seq_pc);
        case (op_q)
          2'b00: begin
            taken_d    = cond_hit;
            cond_err_d = cond_bad;
            target_d   = rel_target;
          end
          2'b01: begin
            taken_d    = 1'b1;
            cond_err_d = 1'b0;
            target_d   = rel_target;
          end
          default: begin
            taken_d    = 1'b1;
            cond_err_d = 1'b0;
            target_d   = reg_q;
          end
        endcase
        state_d = COMMIT;
      end
      COMMIT: begin
        pc_d    = taken_q ? target_q : seq_pc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      status_q   <= '0;
      op_q       <= '0;
      cond_q     <= '0;
      imm_q      <= '0;
      reg_q      <= '0;
      pcs_q      <= '0;
      snap_q     <= '0;
      taken_q    <= 1'b0;
      cond_err_q <= 1'b0;
      target_q   <= '0;
      link_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      status_q   <= status_d;
      op_q       <= op_d;
      cond_q     <= cond_d;
      imm_q      <= imm_d;
      reg_q      <= reg_d;
      pcs_q      <= pcs_d;
      snap_q     <= snap_d;
      taken_q    <= taken_d;
      cond_err_q <= cond_err_d;
      target_q   <= target_d;
      link_q     <= link_d;
    end
  end

  // Outputs: done/link_we are decoded from COMMIT so a reset kills them immediately.
  always_comb begin
    br.br_ready  = (state_q == IDLE);
    br.done      = (state_q == COMMIT);
    br.link_we   = (state_q == COMMIT) && op_q[0];
    br.taken     = taken_q;
    br.cond_err  = cond_err_q;
    br.link_data = link_q;
    pc           = pc_q;
    status       = status_q;
  end

endmodule

// File: tb/tb_branch_unit.sv
// Randomized and directed bench for branch_unit with a queue-based scoreboard.
// The driver predicts each branch outcome from the ISA rules; the monitor checks on done.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
module tb_branch_unit;
  localparam int PCM = 512;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flag_load, N_in, V_in, Z_in, pc_inc;
  logic [8:0] pc;
  logic [2:0] status;

  branch_unit_if bif();

  branch_unit #(.PC_W(9), .RESET_PC(9'h000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flag_load (flag_load),
    .N_in      (N_in),
    .V_in      (V_in),
    .Z_in      (Z_in),
    .pc_inc    (pc_inc),
    .pc        (pc),
    .status    (status),
    .br        (bif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit tk;
    bit ce;
    int npc;
    bit lwe;
    int ldat;
    int acc;
  } exp_t;

  exp_t     sbq[$];
  exp_t     mon_e;
  int       mpc;
  bit [2:0] mst;
  bit       pc_pend = 0;
  int       pc_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every done against the oldest prediction.
  always @(negedge clk) begin
    if (pc_pend) begin
      chk("pc_after_commit", pc, pc_exp);
      pc_pend = 0;
    end
    if (bif.done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", bif.done, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("taken", bif.taken, mon_e.tk);
        chk("cond_err", bif.cond_err, mon_e.ce);
        chk("link_we", bif.link_we, mon_e.lwe);
        if (mon_e.lwe) chk("link_data", bif.link_data, mon_e.ldat);
        chk("latency", cyc - mon_e.acc, 2);
        pc_exp  = mon_e.npc;
        pc_pend = 1;
      end
    end else if (bif.link_we !== 1'b0) begin
      chk("link_we_without_done", bif.link_we, 0);
    end
  end

  // Reference model of a branch from the current architectural pc/status.
  function automatic exp_t model(input bit [1:0] op, input bit [2:0] cond,
                                 input bit [7:0] imm, input bit [15:0] rg);
    exp_t e;
    bit   n, v, z;
    int   rel, seq;
    {n, v, z} = mst;
    seq   = (mpc + 1) % PCM;
    rel   = (mpc + 1 + int'($signed(imm))) & (PCM - 1);
    e.tk  = 0;
    e.ce  = 0;
    e.lwe = 0;
    e.ldat = mpc + 1;
    e.acc = cyc;
    e.npc = seq;
    case (op)
      2'd0: begin
        case (cond)
          3'd0:    e.tk = 1;
          3'd1:    e.tk = z;
          3'd2:    e.tk = !z;
          3'd3:    e.tk = n ^ v;
          3'd4:    e.tk = (n ^ v) | z;
          default: e.ce = 1;
        endcase
        e.npc = e.tk ? rel : seq;
      end
      2'd1: begin e.tk = 1; e.lwe = 1; e.npc = rel; end
      2'd2: begin e.tk = 1; e.npc = rg % PCM; end
      default: begin e.tk = 1; e.lwe = 1; e.npc = rg % PCM; end
    endcase
    return e;
  endfunction

  task automatic idle_cycle(input bit inc, input bit fl, input bit [2:0] f);
    chk("br_ready_idle", bif.br_ready, 1);
    chk("pc_idle", pc, mpc);
    chk("status", status, mst);
    bif.br_valid = 0;
    pc_inc       = inc;
    flag_load    = fl;
    {N_in, V_in, Z_in} = f;
    @(posedge clk); #1;
    pc_inc    = 0;
    flag_load = 0;
    if (fl) mst = f;
    if (inc) mpc = (mpc + 1) % PCM;
  endtask

  task automatic branch(input bit [1:0] op, input bit [2:0] cond, input bit [7:0] imm,
                        input bit [15:0] rg, input bit inc, input bit fl,
                        input bit [2:0] f, input bit do_reset);
    exp_t     e;
    bit       fl2;
    bit [2:0] f2;
    chk("br_ready_accept", bif.br_ready, 1);
    chk("pc_accept", pc, mpc);
    e = model(op, cond, imm, rg);
    sbq.push_back(e);
    bif.br_valid = 1;
    bif.br_op    = op;
    bif.br_cond  = cond;
    bif.br_imm   = imm;
    bif.br_reg   = rg;
    pc_inc       = inc;
    flag_load    = fl;
    {N_in, V_in, Z_in} = f;
    @(posedge clk); #1;
    if (fl) mst = f;
    chk("br_ready_busy", bif.br_ready, 0);
    if (do_reset) begin
      void'(sbq.pop_back());
      bif.br_valid = 0;
      pc_inc = 0;
      flag_load = 0;
      reset_n = 0;
      #1;
      chk("pc_mid_reset", pc, 0);
      chk("status_mid_reset", status, 0);
      chk("ready_mid_reset", bif.br_ready, 1);
      mpc = 0;
      mst = 0;
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1;
      return;
    end
    // Junk on the request inputs while busy; only flag_load may take effect.
    repeat (2) begin
      bif.br_valid = 1'($urandom);
      pc_inc       = 1'($urandom);
      fl2          = 1'($urandom);
      f2           = 3'($urandom);
      flag_load    = fl2;
      {N_in, V_in, Z_in} = f2;
      bif.br_imm   = 8'($urandom);
      @(posedge clk); #1;
      if (fl2) mst = f2;
    end
    bif.br_valid = 0;
    pc_inc       = 0;
    flag_load    = 0;
    mpc = e.npc;
  endtask

  task automatic set_pc(input int v);
    branch(2'd2, 3'd0, 8'h00, 16'(v), 0, 0, 3'b000, 0);
  endtask

  initial begin
    bit [1:0] rop;
    reset_n = 0;
    flag_load = 0; N_in = 0; V_in = 0; Z_in = 0; pc_inc = 0;
    bif.br_valid = 0; bif.br_op = 0; bif.br_cond = 0; bif.br_imm = 0; bif.br_reg = 0;
    mpc = 0;
    mst = 0;
    #2;
    chk("rst_pc", pc, 0);
    chk("rst_status", status, 0);
    chk("rst_ready", bif.br_ready, 1);
    chk("rst_done", bif.done, 0);
    chk("rst_taken", bif.taken, 0);
    chk("rst_cond_err", bif.cond_err, 0);
    chk("rst_link_we", bif.link_we, 0);
    chk("rst_link_data", bif.link_data, 0);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;

    repeat (3) idle_cycle(1, 0, 3'b000);
    chk("pc_after_3_inc", pc, 3);

    // BEQ/BNE with Z=1 at 0x010.
    idle_cycle(0, 1, 3'b001);
    set_pc(16'h010);
    branch(2'd0, 3'd1, 8'hFE, 16'h0, 0, 0, 3'b000, 0);
    set_pc(16'h010);
    branch(2'd0, 3'd2, 8'hFE, 16'h0, 0, 0, 3'b000, 0);

    // BLT with wrap, then not taken.
    idle_cycle(0, 1, 3'b100);
    set_pc(16'h1FD);
    branch(2'd0, 3'd3, 8'h05, 16'h0, 0, 0, 3'b000, 0);
    idle_cycle(0, 1, 3'b110);
    set_pc(16'h1FD);
    branch(2'd0, 3'd3, 8'h05, 16'h0, 0, 0, 3'b000, 0);

    // BL then BLX.
    set_pc(16'h020);
    branch(2'd1, 3'd7, 8'h03, 16'h0, 0, 0, 3'b000, 0);
    chk("pc_after_bl", pc, 16'h024);
    branch(2'd3, 3'd5, 8'h00, 16'hFE40, 0, 0, 3'b000, 0);
    chk("pc_after_blx", pc, 16'h040);

    // Illegal condition, branch+pc_inc collision, flag_load on accept edge.
    branch(2'd0, 3'd6, 8'h10, 16'h0, 0, 0, 3'b000, 0);
    branch(2'd0, 3'd0, 8'h08, 16'h0, 1, 0, 3'b000, 0);
    idle_cycle(0, 1, 3'b000);
    branch(2'd0, 3'd1, 8'h20, 16'h0, 0, 1, 3'b001, 0);
    idle_cycle(0, 0, 3'b000);

    // Reset while in EVAL, then a normal branch.
    set_pc(16'h055);
    branch(2'd1, 3'd0, 8'h04, 16'h0, 0, 0, 3'b000, 1);
    idle_cycle(0, 0, 3'b000);
    branch(2'd1, 3'd0, 8'h04, 16'h0, 0, 0, 3'b000, 0);

    // Randomized mix.
    for (int i = 0; i < 250; i++) begin
      int nidle;
      nidle = $urandom_range(0, 3);
      for (int k = 0; k < nidle; k++)
        idle_cycle(1'($urandom), 1'($urandom), 3'($urandom));
      rop = 2'($urandom);
      if (rop[0] && mpc == PCM - 1) rop[0] = 1'b0;
      branch(rop, 3'($urandom), 8'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom), 3'($urandom), 0);
    end

    idle_cycle(0, 0, 3'b000);
    idle_cycle(0, 0, 3'b000);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
